alu_seq_muldiv: RTL and testbench

Parametrised, registered ALU for the MIPS datapath. It generalises the combinational ALU to WIDTH bits and variable shift/rotate amounts. It adds a multi-cycle unsigned multiply/divide unit that writes results to Hi/Lo registers. A Start/Busy/Done handshake lets the control unit stall the pipeline during multi-cycle operations.

---
 rtl/alu_seq_muldiv_if.sv | 26 ++
 rtl/alu_seq_muldiv.sv | 207 ++++++++++++++++++++
 tb/tb_alu_seq_muldiv.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_muldiv_if.sv
// Operand/result bus between the control unit (master) and the sequential ALU (slave).
interface alu_seq_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             zero;
  logic             busy;
  logic             done;
  logic             div_err;

  modport master (
    output start, a, b, op,
    input  out, hi, lo, zero, busy, done, div_err
  );

  modport slave (
    input  start, a, b, op,
    output out, hi, lo, zero, busy, done, div_err
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Registered WIDTH-bit ALU with a one-bit-per-cycle unsigned multiply/divide unit
// writing Hi/Lo, and a Start/Busy/Done handshake for pipeline stalls.
module alu_seq_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic              clk_i,
  input logic              rst_i,
  alu_seq_muldiv_if.slave  bus
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b1001;
  localparam logic [3:0] OP_SRL   = 4'b1010;
  localparam logic [3:0] OP_ROL   = 4'b1100;
  localparam logic [3:0] OP_ROR   = 4'b1101;
  localparam logic [3:0] OP_MULTU = 4'b1110;
  localparam logic [3:0] OP_DIVU  = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_err_q, div_err_d;

  logic [SHW-1:0]     sh_c;
  logic [SHW:0]       sh_inv_c;
  logic [WIDTH-1:0]   alu_c;
  logic [WIDTH:0]     mul_sum_c;
  logic [2*WIDTH:0]   mul_next_c;
  logic [WIDTH:0]     div_part_c;
  logic [WIDTH:0]     div_diff_c;
  logic               div_ge_c;
  logic [2*WIDTH:0]   div_next_c;
  logic               last_c;

  // Single-cycle datapath; rotates combine two opposing shifts (shift by WIDTH yields 0).
  always_comb begin
    sh_c     = bus.b[SHW-1:0];
    sh_inv_c = (SHW+1)'(WIDTH) - {1'b0, sh_c};
    alu_c    = '0;
    unique case (bus.op)
      OP_ADD:  alu_c = bus.a + bus.b;
      OP_SUB:  alu_c = bus.a - bus.b;
      OP_AND:  alu_c = bus.a & bus.b;
      OP_OR:   alu_c = bus.a | bus.b;
      OP_XOR:  alu_c = bus.a ^ bus.b;
      OP_NOR:  alu_c = ~(bus.a | bus.b);
      OP_SLT:  alu_c = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: alu_c = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_SRA:  alu_c = $signed(bus.a) >>> sh_c;
      OP_SLL:  alu_c = bus.a << sh_c;
      OP_SRL:  alu_c = bus.a >> sh_c;
      OP_ROL:  alu_c = (bus.a << sh_c) | (bus.a >> sh_inv_c);
      OP_ROR:  alu_c = (bus.a >> sh_c) | (bus.a << sh_inv_c);
      default: alu_c = '0;
    endcase
  end

  // Shift-add multiply: acc = {partial (WIDTH+1), multiplier (WIDTH)}, shifted right each step.
  always_comb begin
    mul_sum_c  = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next_c = {mul_sum_c, acc_q[WIDTH-1:0]} >> 1;
  end

  // Restoring divide: acc[2W-1:W] = remainder, acc[W-1:0] = dividend shifting into quotient.
  always_comb begin
    div_part_c = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge_c   = div_part_c >= {1'b0, opnd_q};
    div_diff_c = div_part_c - {1'b0, opnd_q};
    div_next_c = {1'b0,
                  (div_ge_c ? div_diff_c[WIDTH-1:0] : div_part_c[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], div_ge_c};
  end

  assign last_c = (cnt_q == SHW'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    out_d     = out_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    zero_d    = zero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    div_err_d = div_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          div_err_d = 1'b0;
          cnt_d     = '0;
          if (bus.op == OP_MULTU) begin
            acc_d   = {{(WIDTH+1){1'b0}}, bus.b};
            opnd_d  = bus.a;
            busy_d  = 1'b1;
            state_d = S_MUL;
          end else if (bus.op == OP_DIVU) begin
            if (bus.b == '0) begin
              lo_d      = '1;
              hi_d      = bus.a;
              out_d     = '1;
              zero_d    = 1'b0;
              div_err_d = 1'b1;
              done_d    = 1'b1;
            end else begin
              acc_d   = {{(WIDTH+1){1'b0}}, bus.a};
              opnd_d  = bus.b;
              busy_d  = 1'b1;
              state_d = S_DIV;
            end
          end else begin
            out_d  = alu_c;
            zero_d = (alu_c == '0);
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next_c;
        cnt_d = cnt_q + SHW'(1);
        if (last_c) begin
          hi_d    = mul_next_c[2*WIDTH-1:WIDTH];
          lo_d    = mul_next_c[WIDTH-1:0];
          out_d   = mul_next_c[WIDTH-1:0];
          zero_d  = (mul_next_c[WIDTH-1:0] == '0);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        acc_d = div_next_c;
        cnt_d = cnt_q + SHW'(1);
        if (last_c) begin
          hi_d    = div_next_c[2*WIDTH-1:WIDTH];
          lo_d    = div_next_c[WIDTH-1:0];
          out_d   = div_next_c[WIDTH-1:0];
          zero_d  = (div_next_c[WIDTH-1:0] == '0);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      out_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      zero_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      out_q     <= out_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      zero_q    <= zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      div_err_q <= div_err_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.zero    = zero_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.div_err = div_err_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench for alu_seq_muldiv (WIDTH=32): expected results queued at issue,
// compared by a monitor whenever Done pulses.
module tb_alu_seq_muldiv;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_seq_muldiv_if #(.WIDTH(W)) bus ();
  alu_seq_muldiv #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model, independent of the shift-add / restoring implementation.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [63:0] p;
    logic [4:0]  sh;
    logic [W-1:0] r;
    sh = b[4:0];
    e.hi = m_hi; e.lo = m_lo; e.err = 1'b0; r = '0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a | b);
      4'd6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  r = (a < b) ? 32'd1 : 32'd0;
      4'd8:  r = $signed(a) >>> sh;
      4'd9:  r = a << sh;
      4'd10: r = a >> sh;
      4'd12: begin r = a; for (int i = 0; i < int'(sh); i++) r = {r[W-2:0], r[W-1]}; end
      4'd13: begin r = a; for (int i = 0; i < int'(sh); i++) r = {r[0], r[W-1:1]}; end
      4'd14: begin p = 64'(a) * 64'(b); e.hi = p[63:32]; e.lo = p[31:0]; r = p[31:0]; end
      4'd15: begin
        if (b == '0) begin e.hi = a; e.lo = '1; e.err = 1'b1; end
        else begin e.hi = a % b; e.lo = a / b; end
        r = e.lo;
      end
      default: r = '0;
    endcase
    e.out = r;
    return e;
  endfunction

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 64'(bus.done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("out",     64'(bus.out),     64'(e.out));
        check_eq("hi",      64'(bus.hi),      64'(e.hi));
        check_eq("lo",      64'(bus.lo),      64'(e.lo));
        check_eq("zero",    64'(bus.zero),    64'(e.out == '0));
        check_eq("div_err", 64'(bus.div_err), 64'(e.err));
      end
    end
  end

  // Issue one op and track Done latency / Busy duration; 'now' skips the wait for a
  // fresh negedge (used for back-to-back issue in a Done cycle); 'poke' fires a Start while busy.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit now, input bit poke);
    exp_t e;
    int   lat, bcnt, exp_lat;
    bit   seen, multi;
    multi   = (op == 4'd14) || (op == 4'd15 && b != '0);
    exp_lat = multi ? W + 1 : 1;
    if (!now) @(negedge clk);
    e = model(op, a, b);
    m_hi = e.hi; m_lo = e.lo;
    sb.push_back(e);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 4'($urandom);
    lat = 0; bcnt = 0; seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      lat++;
      if (bus.busy) bcnt++;
      if (bus.done) begin seen = 1'b1; break; end
      if (poke && lat == 5) begin bus.start = 1'b1; bus.op = 4'd0; end
      if (poke && lat == 6) bus.start = 1'b0;
    end
    check_eq("done_seen", 64'(seen), 64'd1);
    check_eq("latency",   64'(lat),  64'(exp_lat));
    if (multi) check_eq("busy_cycles", 64'(bcnt), 64'(W));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_out",  64'(bus.out),     64'd0);
    check_eq("rst_hi",   64'(bus.hi),      64'd0);
    check_eq("rst_lo",   64'(bus.lo),      64'd0);
    check_eq("rst_zero", 64'(bus.zero),    64'd1);
    check_eq("rst_busy", 64'(bus.busy),    64'd0);
    check_eq("rst_done", 64'(bus.done),    64'd0);
    check_eq("rst_err",  64'(bus.div_err), 64'd0);
    rst = 1'b0;

    run_op(4'd0,  32'd1,        32'd2, 0, 0);
    run_op(4'd1,  32'd2,        32'd2, 0, 0);
    run_op(4'd8,  32'hFFFFFFFF, 32'd2, 0, 0);
    run_op(4'd10, 32'h3FFFFFFF, 32'd2, 0, 0);
    run_op(4'd12, 32'h83FFFFFF, 32'd2, 0, 0);
    run_op(4'd13, 32'h83FFFFFF, 32'd2, 0, 0);
    for (int op = 8; op <= 13; op++)
      if (op != 11) run_op(4'(op), 32'h8765_4321, 32'hFFFF_FFE0, 0, 0);
    run_op(4'd6,  32'hFFFFFFFF, 32'd1, 0, 0);
    run_op(4'd7,  32'hFFFFFFFF, 32'd1, 0, 0);
    run_op(4'd11, 32'h1234,     32'h5,  0, 0);
    run_op(4'd14, 32'hFFFFFFFF, 32'd2, 0, 1);
    run_op(4'd15, 32'd7,        32'd2, 0, 0);
    run_op(4'd15, 32'd5,        32'd0, 0, 0);
    run_op(4'd0,  32'd1,        32'd2, 0, 0);

    // Back-to-back: ADD issued in the MULTU Done cycle.
    run_op(4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);
    run_op(4'd0,  32'd10,        32'd20,        1, 0);

    // Reset in the middle of a MULTU.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd14; bus.a = 32'hFFFFFFFF; bus.b = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("mid_busy", 64'(bus.busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("mrst_out",  64'(bus.out),     64'd0);
    check_eq("mrst_hi",   64'(bus.hi),      64'd0);
    check_eq("mrst_lo",   64'(bus.lo),      64'd0);
    check_eq("mrst_zero", 64'(bus.zero),    64'd1);
    check_eq("mrst_busy", 64'(bus.busy),    64'd0);
    check_eq("mrst_done", 64'(bus.done),    64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op(4'd0, 32'd1, 32'd2, 0, 0);

    // Random mix of all ops, occasionally a zero divisor.
    for (int i = 0; i < 40; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      op = 4'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      run_op(op, a, b, ($urandom_range(0, 1) == 1) && bus.done, 0);
    end

    repeat (5) @(negedge clk);
    check_eq("sb_drain", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
